// File: rtl/ibex_instr_arbiter.sv
// ibex_instr_arbiter
//   Shares one instruction-memory port between the prefetch buffer (P) and a
//   secondary requester (D, debug/loader). Round-robin choice when both
//   request, selection locked while a request waits for grant, and an owner
//   FIFO routes each rvalid back to whoever issued the transaction.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   p_req_i/p_addr_i           prefetch request / address
//   p_gnt_o/p_rvalid_o         prefetch grant / response valid
//   d_req_i/d_addr_i           secondary request / address
//   d_gnt_o/d_rvalid_o         secondary grant / response valid
//   rdata_o                    instr_rdata_i broadcast to both requesters
//   instr_req_o/instr_addr_o   memory request / word-aligned address
//   instr_gnt_i/instr_rvalid_i/instr_rdata_i  memory grant / rvalid / data
//   busy_o                     transactions outstanding or request pending
//   spurious_o                 rvalid seen with nothing outstanding
module ibex_instr_arbiter #(
    parameter int unsigned NumOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        p_req_i,
    input  logic [31:0] p_addr_i,
    output logic        p_gnt_o,
    output logic        p_rvalid_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o,
    output logic        spurious_o
);

    localparam int unsigned CntW = $clog2(NumOutstanding + 1);
    localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(NumOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(NumOutstanding - 1);

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic                      lock_q, lock_d;   // requester locked in HOLD (0=P, 1=D)
    logic                      last_q, last_d;   // last granted requester
    logic [NumOutstanding-1:0] owner_q, owner_d;
    logic [PtrW-1:0]           wptr_q, wptr_d;
    logic [PtrW-1:0]           rptr_q, rptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;

    logic        sel;
    logic        sel_req;
    logic [31:0] sel_addr;
    logic        push;
    logic        pop;

    // Requester selection: fixed while holding, otherwise round-robin.
    always_comb begin
        sel = 1'b0;
        if (state_q == HOLD) begin
            sel = lock_q;
        end else if (p_req_i && d_req_i) begin
            sel = ~last_q;
        end else if (d_req_i) begin
            sel = 1'b1;
        end
    end

    assign sel_req  = sel ? d_req_i  : p_req_i;
    assign sel_addr = sel ? d_addr_i : p_addr_i;

    // Issue depends only on registered count, never on this cycle's rvalid;
    // rst_ni gating keeps combinational outputs quiet while reset is held.
    assign instr_req_o  = rst_ni & sel_req & (cnt_q < MaxCnt);
    assign instr_addr_o = sel_addr & ~32'h3;

    assign push = instr_req_o & instr_gnt_i;
    assign pop  = instr_rvalid_i & (cnt_q != '0);

    assign p_gnt_o    = push & ~sel;
    assign d_gnt_o    = push &  sel;
    assign p_rvalid_o = pop & ~owner_q[rptr_q];
    assign d_rvalid_o = pop &  owner_q[rptr_q];
    assign spurious_o = rst_ni & instr_rvalid_i & (cnt_q == '0);
    assign busy_o     = (cnt_q != '0) | instr_req_o;
    assign rdata_o    = instr_rdata_i;

    // FSM next state and round-robin pointer.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        last_d  = last_q;
        unique case (state_q)
            ARB: begin
                if (instr_req_o && !instr_gnt_i) begin
                    state_d = HOLD;
                    lock_d  = sel;
                end
            end
            HOLD: begin
                if (push || !sel_req) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        if (push) begin
            last_d = sel;
        end
    end

    // Owner FIFO: push never happens when full because issue is blocked.
    always_comb begin
        owner_d = owner_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (push) begin
            owner_d[wptr_q] = sel;
            wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            lock_q  <= 1'b0;
            last_q  <= 1'b1;   // "D granted last" so P wins the first tie
            owner_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ibex_instr_arbiter.sv
module tb_ibex_instr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p_req, d_req;
    logic [31:0] p_addr, d_addr;
    logic        p_gnt, p_rvalid, d_gnt, d_rvalid;
    logic [31:0] rdata;
    logic        ireq;
    logic [31:0] iaddr;
    logic        igNT;
    logic        irvalid;
    logic [31:0] irdata;
    logic        busy, spur;

    int unsigned n_chk;
    int unsigned n_bad;

    ibex_instr_arbiter #(.NumOutstanding(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .p_req_i       (p_req),
        .p_addr_i      (p_addr),
        .p_gnt_o       (p_gnt),
        .p_rvalid_o    (p_rvalid),
        .d_req_i       (d_req),
        .d_addr_i      (d_addr),
        .d_gnt_o       (d_gnt),
        .d_rvalid_o    (d_rvalid),
        .rdata_o       (rdata),
        .instr_req_o   (ireq),
        .instr_addr_o  (iaddr),
        .instr_gnt_i   (igNT),
        .instr_rvalid_i(irvalid),
        .instr_rdata_i (irdata),
        .busy_o        (busy),
        .spurious_o    (spur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply inputs mid-cycle and let combinational outputs settle.
    task automatic drive(input logic pr, input logic [31:0] pa, input logic dr,
                         input logic [31:0] da, input logic g, input logic rv);
        p_req   = pr;
        p_addr  = pa;
        d_req   = dr;
        d_addr  = da;
        igNT    = g;
        irvalid = rv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_bad  = 0;
        irdata = 32'hCAFE_F00D;
        rst_n  = 1'b0;
        drive(1, 32'h100, 1, 32'h207, 1, 1);

        // Reset: everything quiet despite active inputs.
        check("rst_req",  ireq,     0);
        check("rst_pgnt", p_gnt,    0);
        check("rst_dgnt", d_gnt,    0);
        check("rst_prv",  p_rvalid, 0);
        check("rst_drv",  d_rvalid, 0);
        check("rst_busy", busy,     0);
        check("rst_spur", spur,     0);
        check("rdata",    rdata,    32'hCAFE_F00D);
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Both requesting, gnt every cycle, rvalid one cycle later.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100, 1, 32'h207, 1, (i > 0));
            check($sformatf("rr_pgnt%0d", i), p_gnt, (i % 2 == 0));
            check($sformatf("rr_dgnt%0d", i), d_gnt, (i % 2 == 1));
            check($sformatf("rr_addr%0d", i), iaddr, (i % 2 == 0) ? 32'h100 : 32'h204);
            check($sformatf("rr_prv%0d", i), p_rvalid, (i > 0) && ((i - 1) % 2 == 0));
            check($sformatf("rr_drv%0d", i), d_rvalid, (i > 0) && ((i - 1) % 2 == 1));
            tick();
        end
        drive(0, 32'h100, 0, 32'h207, 1, 1);
        check("rr_tail_drv", d_rvalid, 1);
        check("rr_tail_req", ireq, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("rr_idle_busy", busy, 0);

        // P at 0x1002 stalled 3 cycles while D also requests.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1002, 1, 32'h5000, 0, 0);
            check($sformatf("hold_addr%0d", i), iaddr, 32'h1000);
            check($sformatf("hold_req%0d", i), ireq, 1);
            check($sformatf("hold_dgnt%0d", i), d_gnt, 0);
            tick();
        end
        drive(1, 32'h1002, 1, 32'h5000, 1, 0);
        check("hold_pgnt", p_gnt, 1);
        check("hold_dgnt_g", d_gnt, 0);
        tick();
        drive(1, 32'h1002, 1, 32'h5000, 1, 0);
        check("hold_next_dgnt", d_gnt, 1);
        check("hold_next_addr", iaddr, 32'h5000);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("hold_drain_prv", p_rvalid, 1);
        check("hold_drain_busy", busy, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("hold_drain_drv", d_rvalid, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("hold_idle", busy, 0);

        // Outstanding limit of 2.
        drive(1, 32'h40, 0, 0, 1, 0);
        check("lim_g1", p_gnt, 1);
        tick();
        drive(1, 32'h44, 0, 0, 1, 0);
        check("lim_g2", p_gnt, 1);
        tick();
        drive(1, 32'h48, 0, 0, 1, 0);
        check("lim_req3", ireq, 0);
        check("lim_gnt3", p_gnt, 0);
        check("lim_busy", busy, 1);
        tick();
        drive(1, 32'h48, 0, 0, 1, 1);
        check("lim_rv_prv", p_rvalid, 1);
        check("lim_rv_req", ireq, 0);
        tick();
        drive(1, 32'h48, 0, 0, 1, 0);
        check("lim_reissue", p_gnt, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("lim_drain_prv", p_rvalid, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("lim_idle", busy, 0);

        // Address changes while holding; D ignored.
        drive(1, 32'h2000, 0, 0, 0, 0);
        check("chg_addr0", iaddr, 32'h2000);
        tick();
        drive(1, 32'h3004, 1, 32'h7000, 0, 0);
        check("chg_addr1", iaddr, 32'h3004);
        tick();
        drive(1, 32'h3004, 1, 32'h7000, 1, 0);
        check("chg_pgnt", p_gnt, 1);
        check("chg_dgnt", d_gnt, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("chg_prv", p_rvalid, 1);
        check("chg_drv", d_rvalid, 0);
        tick();

        // Locked requester withdraws: no issue, back to arbitration.
        drive(1, 32'h80, 0, 0, 0, 0);
        tick();
        drive(0, 32'h80, 1, 32'h90, 0, 0);
        check("drop_req", ireq, 0);
        check("drop_dgnt", d_gnt, 0);
        tick();
        drive(0, 0, 1, 32'h90, 1, 0);
        check("drop_dgnt_after", d_gnt, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("drop_drv", d_rvalid, 1);
        tick();

        // Spurious rvalid with nothing outstanding.
        drive(0, 0, 0, 0, 0, 1);
        check("spur_on", spur, 1);
        check("spur_prv", p_rvalid, 0);
        check("spur_drv", d_rvalid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("spur_off", spur, 0);

        // Reset with two outstanding discards ownership.
        drive(1, 32'h10, 0, 0, 1, 0);
        tick();
        drive(1, 32'h14, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        check("post_spur", spur, 1);
        check("post_prv", p_rvalid, 0);
        check("post_busy", busy, 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
